// File: rtl/ifu_idu_queue.sv
// Instruction queue between the IFU and the IDU.
// Buffers fetched {pc, instr} pairs in a small circular FIFO so that an IDU
// stall does not drop an in-flight fetch. A flush (taken branch) discards
// every wrong-path entry at the next clock edge.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high and flush is low. The producer holds its data
// stable while valid & ~ready; once out_valid is high the head entry stays
// stable until it is popped or flushed. in_ready and out_valid are decoded
// from registered occupancy only, so neither has a combinational path from
// out_ready or flush. A pop from a full queue therefore frees the slot for
// the following cycle, not the current one.
module ifu_idu_queue #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          stall,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

  // Entry layout: {pc, instr}
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Status decoded purely from the occupancy register.
  assign in_ready  = (count != FULL_COUNT);
  assign stall     = ~in_ready;
  assign out_valid = (count != '0);

  // A flush cancels any transfer requested in the same cycle.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Empty queue presents pc 0 and a NOP so the IDU always sees a benign word.
  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head[63:32] : 32'h0;
  assign out_instr = out_valid ? head[31:0]  : NOP_INSTR;

  // Pointer and occupancy update; flush returns the queue to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Self-checking bench for ifu_idu_queue (DEPTH = 2).
// The driver updates a reference occupancy and an expected-entry queue at
// each active edge; a monitor on the falling edge pops and compares whenever
// the DUT hands an entry to the IDU. Directed status checks are hand-computed.
module tb_ifu_idu_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic          in_ready;
  logic          stall;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  int          m_count = 0;

  ifu_idu_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .stall(stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one edge; update the reference model from the driven inputs.
  task automatic cycle();
    bit p, q;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_count = 0;
    end else if (flush) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      p = in_valid && (m_count != DEPTH);
      q = (m_count != 0) && out_ready;
      if (p) exp_q.push_back({in_pc, in_instr});
      m_count = m_count + int'(p) - int'(q);
    end
    #1;
  endtask

  // scoreboard monitor: compare head on every IDU transfer, and the idle outputs
  always @(negedge clk) begin
    if (!rst) begin
      check("stall_vs_ready", {31'b0, stall}, {31'b0, ~in_ready});
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h with no expected entry", out_pc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("sb_pc", out_pc, e[63:32]);
          check("sb_instr", out_instr, e[31:0]);
        end
      end else if (!out_valid) begin
        check("idle_pc", out_pc, 32'h0);
        check("idle_instr", out_instr, 32'h0000_0013);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);

    // Single pass
    drive(1, 32'h8000_0000, 32'h0010_0093, 1, 0);
    cycle();
    check("single_valid", {31'b0, out_valid}, 1);
    check("single_pc", out_pc, 32'h8000_0000);
    check("single_instr", out_instr, 32'h0010_0093);
    drive(0, 0, 0, 1, 0);
    cycle();
    check("single_drained", {31'b0, out_valid}, 0);

    // Back-pressure / full
    drive(1, 32'h8000_0000, 32'h0000_0a01, 0, 0);
    cycle();
    drive(1, 32'h8000_0004, 32'h0000_0a02, 0, 0);
    cycle();
    check("full_count", 32'(count), 2);
    check("full_in_ready", {31'b0, in_ready}, 0);
    check("full_stall", {31'b0, stall}, 1);
    drive(1, 32'h8000_0008, 32'h0000_0a03, 0, 0);
    cycle();
    check("full_reject_count", 32'(count), 2);
    check("full_head_pc", out_pc, 32'h8000_0000);
    // Full + pop with pending push: pop only this edge
    drive(1, 32'h8000_0008, 32'h0000_0a03, 1, 0);
    cycle();
    check("fullpop_count", 32'(count), 1);
    check("fullpop_head", out_pc, 32'h8000_0004);
    cycle();
    check("late_push_count", 32'(count), 1);
    check("late_push_head", out_pc, 32'h8000_0008);
    drive(0, 0, 0, 1, 0);
    cycle();
    check("bp_drained", 32'(count), 0);

    // Streaming push+pop across pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h8000_0020 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1, 0);
      cycle();
      check("stream_count", 32'(count), 1);
      check("stream_head", out_pc, 32'h8000_0020 + 32'(4 * i));
    end
    drive(0, 0, 0, 1, 0);
    cycle();
    check("stream_drained", 32'(count), 0);

    // Flush with simultaneous push and pop request
    drive(1, 32'h8000_0200, 32'h0000_0b01, 0, 0);
    cycle();
    drive(1, 32'h8000_0204, 32'h0000_0b02, 0, 0);
    cycle();
    check("preflush_count", 32'(count), 2);
    drive(1, 32'h8000_0010, 32'h0000_0b03, 1, 1);
    cycle();
    check("flush_count", 32'(count), 0);
    check("flush_out_valid", {31'b0, out_valid}, 0);
    check("flush_in_ready", {31'b0, in_ready}, 1);
    drive(1, 32'h8000_0100, 32'h0000_0b04, 0, 0);
    cycle();
    check("postflush_pc", out_pc, 32'h8000_0100);
    check("postflush_count", 32'(count), 1);
    drive(0, 0, 0, 1, 0);
    cycle();
    check("postflush_drained", 32'(count), 0);

    // Asynchronous reset mid-stream with count=2
    drive(1, 32'h8000_0300, 32'h0000_0c01, 0, 0);
    cycle();
    drive(1, 32'h8000_0304, 32'h0000_0c02, 0, 0);
    cycle();
    check("prerst_count", 32'(count), 2);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    exp_q.delete();
    m_count = 0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_out_valid", {31'b0, out_valid}, 0);
    check("arst_out_pc", out_pc, 32'h0);
    check("arst_out_instr", out_instr, 32'h0000_0013);
    check("arst_in_ready", {31'b0, in_ready}, 1);
    check("arst_stall", {31'b0, stall}, 0);
    cycle();
    rst = 1'b0;
    // First push right after reset release
    drive(1, 32'h8000_0400, 32'h0000_0d01, 0, 0);
    cycle();
    check("postrst_count", 32'(count), 1);
    check("postrst_pc", out_pc, 32'h8000_0400);
    drive(0, 0, 0, 1, 0);
    cycle();
    cycle();

    check("sb_empty_at_end", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
